// File: rtl/data_sram_like_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like bridge.
package data_sram_like_bridge_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    function automatic logic is_store(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// SRAM-like bus between the data bridge (master) and the cache/AXI side (slave).
interface data_sram_like_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        input  bus_addr_ok,
        input  bus_data_ok,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        output bus_addr_ok,
        output bus_data_ok,
        output bus_rdata
    );

endinterface

// File: rtl/data_sram_like_bridge.sv
// Turns the M-stage single-cycle data-SRAM access into one SRAM-like bus transaction,
// stalling the pipeline until the data phase completes and holding the load data afterwards.
module data_sram_like_bridge
    import data_sram_like_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    data_sram_like_bridge_if.master bus
);

    state_e            state_q, state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              req_ld;
    logic              rdata_ld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_ld) begin
                wr_q    <= is_store(data_wen);
                size_q  <= data_size_i;
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
            end
            if (rdata_ld) begin
                rdata_q <= bus.bus_rdata;
            end
        end
    end

    // Once issued, a transaction runs to its data phase; flush only matters in IDLE/DONE.
    always_comb begin
        state_d    = state_q;
        req_ld     = 1'b0;
        rdata_ld   = 1'b0;
        data_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_en && !flush) begin
                    req_ld     = 1'b1;
                    data_stall = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                data_stall = 1'b1;
                if (bus.bus_addr_ok) begin
                    if (bus.bus_data_ok) begin
                        rdata_ld = 1'b1;
                        state_d  = StDone;
                    end else begin
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                data_stall = 1'b1;
                if (bus.bus_data_ok) begin
                    rdata_ld = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!pipe_stall || flush) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.bus_req   = (state_q == StReq);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = size_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign data_rdata    = rdata_q;

endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
Memory-stage bridge between the pipeline's single-cycle data-SRAM port and the request/acknowledge SRAM-like bus toward the cache/AXI side. The pipeline presents address, write-enable, size and write data in M. The bridge issues one bus transaction and stalls the pipeline until the data phase completes. It then holds the read data stable while the rest of the pipeline is still stalled.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-low (clears on the clk edge where rst=0)
data_en  in  1  M-stage memory access valid (load or store)
data_wen  in  4  byte write enables (sel); nonzero means store
data_size_i  in  2  access size: 0=byte, 1=half, 2=word
data_addr  in  ADDR_W  M-stage address (aluoutM)
data_wdata  in  DATA_W  aligned store data
flush  in  1  M-stage exception flush (excepttypeM != 0)
pipe_stall  in  1  stall from other sources (i-side bridge, divider)
data_rdata  out  DATA_W  load data to M stage
data_stall  out  1  stall request to hazard unit
bus_req  out  1  bus request
bus_wr  out  1  1=write
bus_size  out  2  latched size
bus_addr  out  ADDR_W  latched address
bus_wdata  out  DATA_W  latched write data
bus_addr_ok  in  1  address phase accepted
bus_data_ok  in  1  data phase complete
bus_rdata  in  DATA_W  read data, valid with bus_data_ok

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (rst=0 at a clk edge): state=IDLE; bus_req=0; bus_wr=0; bus_size=0; bus_addr=0; bus_wdata=0; rdata buffer=0; data_stall=0. Reset mid-transaction abandons it immediately.
- IDLE:
  - If data_en & ~flush, latch addr, size, wdata and wr=(data_wen!=0), then go to REQ.
  - data_stall=1 combinationally in this cycle.
  - If flush=1, no request is issued.
- REQ:
  - bus_req=1; latched fields are held stable.
  - On addr_ok & data_ok in the same cycle: capture bus_rdata and go to DONE.
  - On addr_ok alone: go to WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - bus_req=0.
  - On data_ok: capture bus_rdata into the buffer and go to DONE.
  - For a write, the buffer is still loaded; its value is don't-care.
- DONE:
  - data_stall=0; data_rdata=buffer.
  - If pipe_stall=0 or flush=1, go to IDLE. Otherwise hold DONE with data_rdata stable.
- data_stall = (state==IDLE & data_en & ~flush) | state==REQ | state==WAIT.
- flush is ignored in REQ/WAIT. An issued transaction can never be cancelled and always completes through the data phase.
- bus_req is asserted only from state REQ, i.e. it is registered and never combinational from inputs.
- At most one outstanding transaction.
- Minimum latency with addr_ok same cycle and data_ok next cycle: data_en at cycle n → bus_req at n+1 → DONE at n+3.
- Back-to-back accesses: DONE→IDLE costs one cycle before the next request.
- data_rdata in IDLE/REQ/WAIT = buffer (last value). Consumers sample it only when data_stall=0.

Decomposition:
- Shared package (cpu_defines): state encoding localparams, SIZE_BYTE/HALF/WORD constants.
- Sub-modules: none. One flopenr-style hold register for the request fields is acceptable.

Test Plan:
- Word load, addr=0x8000_0010: addr_ok at n+1, data_ok at n+2 with rdata=0xDEAD_BEEF → bus_req high exactly 1 cycle, data_stall high 3 cycles, data_rdata=0xDEADBEEF in DONE.
- Byte store, wen=4'b0100, addr=0x...2, wdata=0x00AB_0000: addr_ok delayed 4 cycles → bus_wr=1, bus_size=0, address and data stable throughout REQ, data_stall held until data_ok.
- Load completes while pipe_stall=1 for 3 cycles → stay in DONE, data_rdata constant, data_stall=0, return to IDLE the cycle pipe_stall falls.
- flush=1 with data_en=1 in IDLE → no bus_req ever, data_stall=0. flush raised during WAIT → transaction completes, then IDLE.
- addr_ok and data_ok in the same cycle as req → IDLE→REQ→DONE, latency of 2 cycles.
- rst=0 asserted during WAIT → next cycle IDLE, bus_req=0, data_stall=0, buffer=0. A stale data_ok afterwards is ignored.
